mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Arbitrates the single byte-wide RAM port between three requesters: instruction fetcher (4-byte reads), LSB loads (1/2/4-byte reads with optional sign extension) and ROB-committed stores (1/2/4-byte writes).
- Serialises each request into per-byte RAM cycles, assembles read data little-endian, and returns a one-cycle done pulse to the owning requester.
- Sits between the fetcher/LSB/ROB and the top-level RAM/IO pins.

Parameters:
IO_REGION, 2'b11, value of address bits [17:16] that marks the IO space.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous active-high reset.
rdy  in  1  global ready; when low, all state holds.
in_fetcher_flag  in  1  one-cycle fetch request pulse.
in_fetcher_addr  in  32  fetch address.
out_fetcher_flag  out  1  fetch done pulse.
out_fetcher_data  out  32  fetched instruction word.
in_lsb_flag  in  1  one-cycle load request pulse.
in_lsb_size  in  6  load byte count: 1, 2 or 4.
in_lsb_signed  in  1  1 = sign-extend, 0 = zero-extend.
in_lsb_addr  in  32  load address.
out_lsb_flag  out  1  load done pulse.
out_lsb_data  out  32  extended load result.
in_rob_flag  in  1  one-cycle store request pulse.
in_rob_size  in  6  store byte count: 1, 2 or 4.
in_rob_addr  in  32  store address.
in_rob_data  in  32  store data; low bytes used.
out_rob_flag  out  1  store done pulse.
in_rob_xbp  in  1  branch mispredict flush.
mem_din  in  8  RAM read byte.
mem_dout  out  8  RAM write byte.
mem_a  out  32  RAM byte address.
mem_wr  out  1  1 = write, 0 = read.
io_buffer_full  in  1  IO output buffer full.

Behaviour:
- Reset (async, rst=1): state IDLE; all pending and valid bits cleared; byte counter 0; mem_a=0, mem_dout=0, mem_wr=0; all out_*_flag=0; all out_*_data=0.
- rdy low: no register changes and no input sampling. Requesters are rdy-gated as well.
- Request capture (rdy=1): each in_*_flag pulse latches address, size, signed and data into that requester's pending slot, in the same edge, even while another transfer is active. At most one outstanding request per requester; a second pulse before done is a protocol violation.
- Arbitration in IDLE: fixed priority store > load > fetch. The grant edge moves the pending slot to active and clears pending. No preemption once a transfer starts.
- IO gate: a pending store with addr[17:16]==IO_REGION is not granted while io_buffer_full=1. In that case a lower-priority pending request may be granted instead.
- States: IDLE, READ, WRITE. Count cycles from the grant edge as cycle 0.
- READ (size N): mem_wr=0; mem_a=addr+k in cycle k+1, for k=0..N-1.
  - Byte k appears on mem_din in cycle k+2 and is captured into result bits [8k+7:8k].
  - The done pulse and data become visible in cycle N+2; the state is IDLE in that same cycle.
  - Fetches always use N=4, unsigned.
  - LSB size 1/2: bits above 8N are filled with the MSB of the top byte if signed, else 0.
- WRITE (size N): mem_wr=1, mem_a=addr+k, mem_dout=data[8k+7:8k] in cycle k+1.
  - mem_wr=0 from cycle N+1; out_rob_flag pulses in cycle N+1, where the state is IDLE.
- Outside active address cycles: mem_wr=0 and mem_a=0.
- Every done flag is high for exactly one cycle. out_*_data holds its value until the next done for that requester.
- Address arithmetic is 32-bit wrapping.
- Flush (in_rob_xbp=1 while rdy=1):
  - Pending fetch and load are cleared; fetch/load pulses in the same cycle are dropped.
  - An active READ aborts: state returns to IDLE next edge, mem_a=0, no done pulse.
  - An active WRITE and any pending store are unaffected, since stores are already committed. A store pulse in the same cycle is accepted.
- Simultaneous done and new request from the same requester in one cycle: the request is legal and is latched.
- Reset mid-transfer: immediate return to the reset state, including mem_wr=0 asynchronously.

Test Plan:
- RAM[0x100..0x103]=13,05,00,00; fetch pulse addr 0x100 -> mem_a 0x100..0x103 in cycles 1-4; out_fetcher_flag in cycle 6 with data 0x00000513.
- RAM[0x200]=0x80; LB signed -> out_lsb_data=0xFFFFFF80. Same address LBU -> 0x00000080. LH at 0x200 with RAM[0x201]=0x7F -> 0x00007F80.
- Store SW addr 0x300 data 0xDEADBEEF -> mem_wr=1 with bytes EF,BE,AD,DE at 0x300..0x303 in cycles 1-4; out_rob_flag in cycle 5; RAM readback 0xDEADBEEF.
- Fetch, load and store pulses in the same cycle while idle -> service order store, load, fetch; exactly one done pulse each; no overlap of mem_a activity.
- Store SB to 0x30000 with io_buffer_full=1 plus a pending fetch -> fetch completes first; store issues only after io_buffer_full drops; mem_dout=the data byte.
- in_rob_xbp in cycle 2 of a fetch with a store pending -> no out_fetcher_flag; the store is then granted and completes. Also assert rst mid-WRITE -> mem_wr=0 immediately and all flags are 0.

Source files
------------

// File: rtl/mem_ctrl.sv
// Byte-serial RAM port arbiter for fetcher, LSB loads and ROB stores.
// Requests are latched into per-requester slots and serviced one at a time, store > load > fetch.
module mem_ctrl #(
  parameter logic [1:0] IO_REGION = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        in_fetcher_flag,
  input  logic [31:0] in_fetcher_addr,
  output logic        out_fetcher_flag,
  output logic [31:0] out_fetcher_data,
  input  logic        in_lsb_flag,
  input  logic [5:0]  in_lsb_size,
  input  logic        in_lsb_signed,
  input  logic [31:0] in_lsb_addr,
  output logic        out_lsb_flag,
  output logic [31:0] out_lsb_data,
  input  logic        in_rob_flag,
  input  logic [5:0]  in_rob_size,
  input  logic [31:0] in_rob_addr,
  input  logic [31:0] in_rob_data,
  output logic        out_rob_flag,
  input  logic        in_rob_xbp,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned SIZE_W = 6;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  typedef struct packed {
    logic [XLEN-1:0]  addr;
    logic [CNT_W-1:0] n;
    logic             sgn;
    logic [XLEN-1:0]  data;
  } req_t;

  state_t           state;
  req_t             fetch_pend, lsb_pend, rob_pend, act;
  logic             fetch_vld, lsb_vld, rob_vld;
  logic             act_is_fetch;
  logic [CNT_W-1:0] cnt;
  logic [23:0]      rd_buf;

  logic             store_ok_c;
  logic             read_done_c;
  logic [XLEN-1:0]  load_word_c;

  function automatic logic [CNT_W-1:0] size_to_n(input logic [SIZE_W-1:0] s);
    case (s)
      6'd1:    size_to_n = 3'd1;
      6'd2:    size_to_n = 3'd2;
      default: size_to_n = 3'd4;
    endcase
  endfunction

  function automatic logic [BYTE_W-1:0] byte_sel(input logic [XLEN-1:0] w,
                                                 input logic [CNT_W-1:0] k);
    case (k[1:0])
      2'd0:    byte_sel = w[7:0];
      2'd1:    byte_sel = w[15:8];
      2'd2:    byte_sel = w[23:16];
      default: byte_sel = w[31:24];
    endcase
  endfunction

  // IO stores wait while the IO output buffer is full; lower priorities may pass them
  assign store_ok_c  = rob_vld && !((rob_pend.addr[17:16] == IO_REGION) && io_buffer_full);
  assign read_done_c = (cnt == act.n + 3'd1);

  // Final byte arrives on mem_din in the done cycle, so it bypasses rd_buf
  always_comb begin
    load_word_c = {mem_din, rd_buf};
    case (act.n)
      3'd1:    load_word_c = {{24{act.sgn & mem_din[7]}}, mem_din};
      3'd2:    load_word_c = {{16{act.sgn & mem_din[7]}}, mem_din, rd_buf[7:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      fetch_pend       <= '0;
      lsb_pend         <= '0;
      rob_pend         <= '0;
      act              <= '0;
      fetch_vld        <= 1'b0;
      lsb_vld          <= 1'b0;
      rob_vld          <= 1'b0;
      act_is_fetch     <= 1'b0;
      cnt              <= '0;
      rd_buf           <= '0;
      mem_a            <= '0;
      mem_dout         <= '0;
      mem_wr           <= 1'b0;
      out_fetcher_flag <= 1'b0;
      out_fetcher_data <= '0;
      out_lsb_flag     <= 1'b0;
      out_lsb_data     <= '0;
      out_rob_flag     <= 1'b0;
    end else if (rdy) begin
      out_fetcher_flag <= 1'b0;
      out_lsb_flag     <= 1'b0;
      out_rob_flag     <= 1'b0;

      case (state)
        IDLE: begin
          mem_wr <= 1'b0;
          mem_a  <= '0;
          cnt    <= '0;
          if (store_ok_c) begin
            act     <= rob_pend;
            rob_vld <= 1'b0;
            state   <= WRITE;
          end else if (!in_rob_xbp && lsb_vld) begin
            act          <= lsb_pend;
            act_is_fetch <= 1'b0;
            lsb_vld      <= 1'b0;
            state        <= READ;
          end else if (!in_rob_xbp && fetch_vld) begin
            act          <= fetch_pend;
            act_is_fetch <= 1'b1;
            fetch_vld    <= 1'b0;
            state        <= READ;
          end
        end

        READ: begin
          if (in_rob_xbp) begin
            state <= IDLE;
            mem_a <= '0;
          end else begin
            cnt   <= cnt + 3'd1;
            mem_a <= (cnt < act.n) ? act.addr + XLEN'(cnt) : '0;
            case (cnt)
              3'd2:    rd_buf[7:0]   <= mem_din;
              3'd3:    rd_buf[15:8]  <= mem_din;
              3'd4:    rd_buf[23:16] <= mem_din;
              default: ;
            endcase
            if (read_done_c) begin
              state <= IDLE;
              if (act_is_fetch) begin
                out_fetcher_flag <= 1'b1;
                out_fetcher_data <= load_word_c;
              end else begin
                out_lsb_flag <= 1'b1;
                out_lsb_data <= load_word_c;
              end
            end
          end
        end

        WRITE: begin
          if (cnt < act.n) begin
            mem_wr   <= 1'b1;
            mem_a    <= act.addr + XLEN'(cnt);
            mem_dout <= byte_sel(act.data, cnt);
            cnt      <= cnt + 3'd1;
          end else begin
            mem_wr       <= 1'b0;
            mem_a        <= '0;
            out_rob_flag <= 1'b1;
            state        <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase

      // Flush drops speculative requests; committed stores survive
      if (in_rob_xbp) begin
        fetch_vld <= 1'b0;
        lsb_vld   <= 1'b0;
      end

      // New requests land last so a pulse coinciding with a grant is never lost
      if (in_fetcher_flag && !in_rob_xbp) begin
        fetch_vld  <= 1'b1;
        fetch_pend <= '{addr: in_fetcher_addr, n: 3'd4, sgn: 1'b0, data: '0};
      end
      if (in_lsb_flag && !in_rob_xbp) begin
        lsb_vld  <= 1'b1;
        lsb_pend <= '{addr: in_lsb_addr, n: size_to_n(in_lsb_size),
                      sgn: in_lsb_signed, data: '0};
      end
      if (in_rob_flag) begin
        rob_vld  <= 1'b1;
        rob_pend <= '{addr: in_rob_addr, n: size_to_n(in_rob_size),
                      sgn: 1'b0, data: in_rob_data};
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: synchronous byte RAM model, expected completions queued in
// service order and matched against done pulses, plus cycle-exact address/write checks.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        in_fetcher_flag;
  logic [31:0] in_fetcher_addr;
  logic        out_fetcher_flag;
  logic [31:0] out_fetcher_data;
  logic        in_lsb_flag;
  logic [5:0]  in_lsb_size;
  logic        in_lsb_signed;
  logic [31:0] in_lsb_addr;
  logic        out_lsb_flag;
  logic [31:0] out_lsb_data;
  logic        in_rob_flag;
  logic [5:0]  in_rob_size;
  logic [31:0] in_rob_addr;
  logic [31:0] in_rob_data;
  logic        out_rob_flag;
  logic        in_rob_xbp;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  mem_ctrl #(.IO_REGION(2'b11)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .in_fetcher_flag(in_fetcher_flag), .in_fetcher_addr(in_fetcher_addr),
    .out_fetcher_flag(out_fetcher_flag), .out_fetcher_data(out_fetcher_data),
    .in_lsb_flag(in_lsb_flag), .in_lsb_size(in_lsb_size), .in_lsb_signed(in_lsb_signed),
    .in_lsb_addr(in_lsb_addr), .out_lsb_flag(out_lsb_flag), .out_lsb_data(out_lsb_data),
    .in_rob_flag(in_rob_flag), .in_rob_size(in_rob_size), .in_rob_addr(in_rob_addr),
    .in_rob_data(in_rob_data), .out_rob_flag(out_rob_flag), .in_rob_xbp(in_rob_xbp),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  // RAM with registered read; IO-region writes are logged instead of stored
  logic [7:0]  ram [0:1023];
  logic [7:0]  io_byte = 8'h00;
  logic [31:0] io_addr = 32'h0;
  int          io_cnt  = 0;
  int          io_bad  = 0;
  always @(posedge clk) begin
    if (mem_wr) begin
      if (mem_a[17:16] == 2'b11) begin
        io_byte <= mem_dout;
        io_addr <= mem_a;
        io_cnt  <= io_cnt + 1;
        if (io_buffer_full) io_bad <= io_bad + 1;
      end else begin
        ram[mem_a[9:0]] <= mem_dout;
      end
    end
    mem_din <= ram[mem_a[9:0]];
  end

  typedef struct {
    int          src;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic expect_done(input int src, input logic [31:0] data);
    exp_t e;
    e.src  = src;
    e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic on_done(input int src, input logic [31:0] d);
    exp_t e;
    if (sb_q.size() == 0) begin
      check("spurious_done", 32'(src), 32'hFFFF_FFFF);
    end else begin
      e = sb_q.pop_front();
      check("done_src", 32'(src), 32'(e.src));
      check("done_data", d, e.data);
    end
  endtask

  // src: 0 fetch, 1 load, 2 store
  always @(negedge clk) begin
    if (!rst) begin
      if (out_fetcher_flag) on_done(0, out_fetcher_data);
      if (out_lsb_flag)     on_done(1, out_lsb_data);
      if (out_rob_flag)     on_done(2, 32'h0);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_fetch(input logic [31:0] a);
    in_fetcher_flag = 1'b1;
    in_fetcher_addr = a;
  endtask

  task automatic set_load(input logic [31:0] a, input logic [5:0] sz, input logic sgn);
    in_lsb_flag   = 1'b1;
    in_lsb_addr   = a;
    in_lsb_size   = sz;
    in_lsb_signed = sgn;
  endtask

  task automatic set_store(input logic [31:0] a, input logic [5:0] sz, input logic [31:0] d);
    in_rob_flag = 1'b1;
    in_rob_addr = a;
    in_rob_size = sz;
    in_rob_data = d;
  endtask

  task automatic clear_pulses;
    in_fetcher_flag = 1'b0;
    in_lsb_flag     = 1'b0;
    in_rob_flag     = 1'b0;
  endtask

  task automatic wait_size(input string tag, input int n, input int budget);
    int k = 0;
    while (sb_q.size() != n && k < budget) begin
      tick;
      k++;
    end
    check(tag, 32'(sb_q.size()), 32'(n));
  endtask

  task automatic do_load(input logic [31:0] a, input logic [5:0] sz, input logic sgn,
                         input logic [31:0] exp);
    expect_done(1, exp);
    set_load(a, sz, sgn);
    tick;
    clear_pulses;
    wait_size("load_drain", 0, 20);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    rst = 1'b1; rdy = 1'b1; in_rob_xbp = 1'b0; io_buffer_full = 1'b0;
    in_fetcher_addr = '0; in_lsb_size = '0; in_lsb_signed = 1'b0; in_lsb_addr = '0;
    in_rob_size = '0; in_rob_addr = '0; in_rob_data = '0;
    clear_pulses;
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    ram[10'h100] = 8'h13; ram[10'h101] = 8'h05; ram[10'h102] = 8'h00; ram[10'h103] = 8'h00;
    ram[10'h200] = 8'h80; ram[10'h201] = 8'h7F; ram[10'h202] = 8'hC5;

    repeat (3) tick;
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_wr", 32'(mem_wr), 32'h0);
    check("rst_mem_dout", 32'(mem_dout), 32'h0);
    check("rst_flags", 32'({out_fetcher_flag, out_lsb_flag, out_rob_flag}), 32'h0);
    check("rst_data", out_fetcher_data | out_lsb_data, 32'h0);
    rst = 1'b0;
    tick;

    // Fetch: addresses in cycles 1-4, done in cycle 6
    expect_done(0, 32'h0000_0513);
    set_fetch(32'h100);
    tick;
    clear_pulses;
    tick;
    for (int c = 1; c <= 6; c++) begin
      tick;
      if (c <= 4) check("fetch_mem_a", mem_a, 32'h100 + 32'(c - 1));
      if (c == 5) check("fetch_early_done", 32'(out_fetcher_flag), 32'h0);
      if (c == 6) check("fetch_done_cycle", 32'(out_fetcher_flag), 32'h1);
    end
    wait_size("fetch_drain", 0, 5);

    // Loads with sign/zero extension
    do_load(32'h200, 6'd1, 1'b1, 32'hFFFF_FF80);
    do_load(32'h200, 6'd1, 1'b0, 32'h0000_0080);
    do_load(32'h200, 6'd2, 1'b1, 32'h0000_7F80);
    do_load(32'h201, 6'd2, 1'b1, 32'hFFFF_C57F);
    do_load(32'h201, 6'd2, 1'b0, 32'h0000_C57F);

    // Word store: bytes little-endian in cycles 1-4, done in cycle 5
    d = 32'hDEAD_BEEF;
    expect_done(2, 32'h0);
    set_store(32'h300, 6'd4, d);
    tick;
    clear_pulses;
    tick;
    for (int c = 1; c <= 5; c++) begin
      tick;
      if (c <= 4) begin
        check("store_wr", 32'(mem_wr), 32'h1);
        check("store_mem_a", mem_a, 32'h300 + 32'(c - 1));
        check("store_dout", 32'(mem_dout), 32'(8'(d >> (8 * (c - 1)))));
      end else begin
        check("store_done_cycle", 32'(out_rob_flag), 32'h1);
        check("store_wr_off", 32'(mem_wr), 32'h0);
      end
    end
    wait_size("store_drain", 0, 5);
    do_load(32'h300, 6'd4, 1'b0, 32'hDEAD_BEEF);

    // Simultaneous requests: store, then load (sees stored byte), then fetch
    expect_done(2, 32'h0);
    expect_done(1, 32'h0000_005A);
    expect_done(0, 32'h0000_0513);
    set_store(32'h310, 6'd1, 32'h1234_565A);
    set_load(32'h310, 6'd1, 1'b0);
    set_fetch(32'h100);
    tick;
    clear_pulses;
    wait_size("prio_drain", 0, 60);

    // IO store blocked by full buffer; fetch overtakes it
    io_buffer_full = 1'b1;
    expect_done(0, 32'h0000_0513);
    expect_done(2, 32'h0);
    set_store(32'h0003_0000, 6'd1, 32'h0000_00A7);
    set_fetch(32'h100);
    tick;
    clear_pulses;
    wait_size("io_fetch_first", 1, 30);
    repeat (10) tick;
    check("io_store_held", 32'(io_cnt), 32'h0);
    check("io_still_pending", 32'(sb_q.size()), 32'h1);
    io_buffer_full = 1'b0;
    wait_size("io_drain", 0, 20);
    check("io_cnt", 32'(io_cnt), 32'h1);
    check("io_byte", 32'(io_byte), 32'h0000_00A7);
    check("io_addr", io_addr, 32'h0003_0000);
    check("io_while_full", 32'(io_bad), 32'h0);

    // Flush in cycle 2 of a fetch with a store pending
    expect_done(2, 32'h0);
    set_fetch(32'h100);
    tick;
    clear_pulses;
    tick;
    set_store(32'h320, 6'd4, 32'h1122_3344);
    tick;
    clear_pulses;
    tick;
    in_rob_xbp = 1'b1;
    tick;
    in_rob_xbp = 1'b0;
    check("flush_mem_a", mem_a, 32'h0);
    wait_size("flush_store_drain", 0, 20);
    repeat (8) tick;
    do_load(32'h320, 6'd4, 1'b0, 32'h1122_3344);

    // Asynchronous reset in the middle of a write
    set_store(32'h330, 6'd4, 32'hCAFE_F00D);
    tick;
    clear_pulses;
    tick;
    tick;
    tick;
    check("pre_rst_wr", 32'(mem_wr), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_wr", 32'(mem_wr), 32'h0);
    check("rst_mid_mem_a", mem_a, 32'h0);
    check("rst_mid_flags", 32'({out_fetcher_flag, out_lsb_flag, out_rob_flag}), 32'h0);
    check("rst_mid_data", out_lsb_data, 32'h0);
    tick;
    rst = 1'b0;
    repeat (6) tick;

    // Recovery after reset
    expect_done(0, 32'h0000_0513);
    set_fetch(32'h100);
    tick;
    clear_pulses;
    wait_size("post_rst_drain", 0, 20);
    repeat (4) tick;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
